mode_queue: RTL and testbench

- Register-based FIFO queue, parametrised in data width, depth and flow-through mode (normal, pipe or bypass).
- Uses the same en/rdy enqueue/dequeue interface and occupancy count as the existing normal queue, so it is a drop-in replacement.
- Adds a synchronous flush and a sticky protocol-error flag.
- Used for router input buffers and channel decoupling where the latency/throughput trade-off varies per instance.

---
 rtl/mode_queue.sv | 120 ++++++++++++
 tb/tb_mode_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_queue.sv
// Register-based FIFO with selectable flow-through mode (0 normal, 1 pipe, 2 bypass),
// synchronous flush and a sticky protocol-error flag.
module mode_queue #(
  parameter int unsigned data_width  = 32,
  parameter int unsigned num_entries = 2,
  parameter int unsigned mode        = 0,
  parameter int unsigned count_width = $clog2(num_entries + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  output logic [count_width-1:0] count,
  input  logic                   enq_en,
  output logic                   enq_rdy,
  input  logic [data_width-1:0]  enq_msg,
  input  logic                   deq_en,
  output logic                   deq_rdy,
  output logic [data_width-1:0]  deq_msg,
  output logic                   err
);

  localparam int unsigned addr_width = (num_entries == 1) ? 1 : $clog2(num_entries);
  localparam logic [addr_width-1:0]  last_addr  = addr_width'(num_entries - 1);
  localparam logic [count_width-1:0] full_count = count_width'(num_entries);

  logic [data_width-1:0]  r_data [num_entries];
  logic [addr_width-1:0]  r_enq_ptr;
  logic [addr_width-1:0]  r_deq_ptr;
  logic [count_width-1:0] r_count;
  logic                   r_err;

  logic [addr_width-1:0]  w_enq_ptr_nxt;
  logic [addr_width-1:0]  w_deq_ptr_nxt;
  logic [count_width-1:0] w_count_nxt;
  logic                   w_err_nxt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_enq_fire;
  logic                   w_deq_fire;
  logic                   w_pass;
  logic                   w_write;

  function automatic logic [addr_width-1:0] ptr_inc(input logic [addr_width-1:0] p);
    return (p == last_addr) ? '0 : p + addr_width'(1);
  endfunction

  assign w_full  = (r_count == full_count);
  assign w_empty = (r_count == '0);

  // Handshake and head-of-queue; pipe/bypass add their combinational shortcuts.
  always_comb begin
    enq_rdy = !w_full;
    deq_rdy = !w_empty;
    deq_msg = r_data[r_deq_ptr];
    if (mode == 1) begin
      enq_rdy = !w_full | deq_en;
    end
    if (mode == 2) begin
      deq_rdy = !w_empty | enq_en;
      if (w_empty) begin
        deq_msg = enq_msg;
      end
    end
  end

  assign w_enq_fire = enq_en & enq_rdy;
  assign w_deq_fire = deq_en & deq_rdy;
  // Empty bypass with both sides firing: message flows straight through untouched.
  assign w_pass     = (mode == 2) & w_empty & w_enq_fire & w_deq_fire;
  assign w_write    = w_enq_fire & !w_pass & !clear;

  always_comb begin
    w_enq_ptr_nxt = r_enq_ptr;
    w_deq_ptr_nxt = r_deq_ptr;
    w_count_nxt   = r_count;
    w_err_nxt     = r_err | (enq_en & !enq_rdy) | (deq_en & !deq_rdy);
    if (clear) begin
      w_enq_ptr_nxt = '0;
      w_deq_ptr_nxt = '0;
      w_count_nxt   = '0;
    end else if (!w_pass) begin
      if (w_enq_fire) begin
        w_enq_ptr_nxt = ptr_inc(r_enq_ptr);
      end
      if (w_deq_fire) begin
        w_deq_ptr_nxt = ptr_inc(r_deq_ptr);
      end
      if (w_enq_fire && !w_deq_fire) begin
        w_count_nxt = r_count + count_width'(1);
      end else if (w_deq_fire && !w_enq_fire) begin
        w_count_nxt = r_count - count_width'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_enq_ptr <= w_enq_ptr_nxt;
      r_deq_ptr <= w_deq_ptr_nxt;
      r_count   <= w_count_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_data[r_enq_ptr] <= enq_msg;
    end
  end

  assign count = r_count;
  assign err   = r_err;

endmodule

// File: tb/tb_mode_queue.sv
// Directed bench for mode_queue: one instance per mode/depth combination under test.
module tb_mode_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] enq_msg;

  int n_checks = 0;
  int n_errors = 0;

  // q0: mode 0, N=2
  logic [1:0] q0_count;
  logic q0_enq_en, q0_enq_rdy, q0_deq_en, q0_deq_rdy, q0_err;
  logic [7:0] q0_deq_msg;
  // q1: mode 1, N=2
  logic [1:0] q1_count;
  logic q1_enq_en, q1_enq_rdy, q1_deq_en, q1_deq_rdy, q1_err;
  logic [7:0] q1_deq_msg;
  // q2: mode 2, N=2
  logic [1:0] q2_count;
  logic q2_enq_en, q2_enq_rdy, q2_deq_en, q2_deq_rdy, q2_err;
  logic [7:0] q2_deq_msg;
  // q3: mode 0, N=3
  logic [1:0] q3_count;
  logic q3_enq_en, q3_enq_rdy, q3_deq_en, q3_deq_rdy, q3_err;
  logic [7:0] q3_deq_msg;
  // q4: mode 0, N=4
  logic [2:0] q4_count;
  logic q4_enq_en, q4_enq_rdy, q4_deq_en, q4_deq_rdy, q4_err;
  logic [7:0] q4_deq_msg;

  mode_queue #(.data_width(8), .num_entries(2), .mode(0)) u_q0 (
    .clk(clk), .reset(reset), .clear(clear), .count(q0_count),
    .enq_en(q0_enq_en), .enq_rdy(q0_enq_rdy), .enq_msg(enq_msg),
    .deq_en(q0_deq_en), .deq_rdy(q0_deq_rdy), .deq_msg(q0_deq_msg), .err(q0_err));

  mode_queue #(.data_width(8), .num_entries(2), .mode(1)) u_q1 (
    .clk(clk), .reset(reset), .clear(clear), .count(q1_count),
    .enq_en(q1_enq_en), .enq_rdy(q1_enq_rdy), .enq_msg(enq_msg),
    .deq_en(q1_deq_en), .deq_rdy(q1_deq_rdy), .deq_msg(q1_deq_msg), .err(q1_err));

  mode_queue #(.data_width(8), .num_entries(2), .mode(2)) u_q2 (
    .clk(clk), .reset(reset), .clear(clear), .count(q2_count),
    .enq_en(q2_enq_en), .enq_rdy(q2_enq_rdy), .enq_msg(enq_msg),
    .deq_en(q2_deq_en), .deq_rdy(q2_deq_rdy), .deq_msg(q2_deq_msg), .err(q2_err));

  mode_queue #(.data_width(8), .num_entries(3), .mode(0)) u_q3 (
    .clk(clk), .reset(reset), .clear(clear), .count(q3_count),
    .enq_en(q3_enq_en), .enq_rdy(q3_enq_rdy), .enq_msg(enq_msg),
    .deq_en(q3_deq_en), .deq_rdy(q3_deq_rdy), .deq_msg(q3_deq_msg), .err(q3_err));

  mode_queue #(.data_width(8), .num_entries(4), .mode(0)) u_q4 (
    .clk(clk), .reset(reset), .clear(clear), .count(q4_count),
    .enq_en(q4_enq_en), .enq_rdy(q4_enq_rdy), .enq_msg(enq_msg),
    .deq_en(q4_deq_en), .deq_rdy(q4_deq_rdy), .deq_msg(q4_deq_msg), .err(q4_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int got;
    int cyc;

    reset = 1'b1;
    clear = 1'b0;
    enq_msg = 8'h00;
    q0_enq_en = 0; q0_deq_en = 0;
    q1_enq_en = 0; q1_deq_en = 0;
    q2_enq_en = 0; q2_deq_en = 0;
    q3_enq_en = 0; q3_deq_en = 0;
    q4_enq_en = 0; q4_deq_en = 0;
    #12 reset = 1'b0;
    step();

    // Reset state
    check("rst_count",   32'(q0_count), 32'd0);
    check("rst_enq_rdy", 32'(q0_enq_rdy), 32'd1);
    check("rst_deq_rdy", 32'(q0_deq_rdy), 32'd0);
    check("rst_err",     32'(q0_err), 32'd0);
    check("rst_byp_deq_rdy", 32'(q2_deq_rdy), 32'd0);

    // Normal mode fill and drain
    q0_enq_en = 1; enq_msg = 8'h11; step();
    enq_msg = 8'h22; step();
    q0_enq_en = 0; #1;
    check("n_full_count",   32'(q0_count), 32'd2);
    check("n_full_enq_rdy", 32'(q0_enq_rdy), 32'd0);
    check("n_head0",        32'(q0_deq_msg), 32'h11);
    q0_deq_en = 1; step();
    check("n_head1", 32'(q0_deq_msg), 32'h22);
    step();
    q0_deq_en = 0; #1;
    check("n_empty_count",   32'(q0_count), 32'd0);
    check("n_empty_deq_rdy", 32'(q0_deq_rdy), 32'd0);

    // Pipe mode: enqueue into a full queue alongside a dequeue
    q1_enq_en = 1; enq_msg = 8'hA1; step();
    enq_msg = 8'hA2; step();
    enq_msg = 8'hA3; q1_deq_en = 1; #1;
    check("p_full_enq_rdy", 32'(q1_enq_rdy), 32'd1);
    check("p_head_a1",      32'(q1_deq_msg), 32'hA1);
    step();
    q1_enq_en = 0; #1;
    check("p_count_held", 32'(q1_count), 32'd2);
    check("p_head_a2",    32'(q1_deq_msg), 32'hA2);
    step();
    check("p_head_a3", 32'(q1_deq_msg), 32'hA3);
    step();
    q1_deq_en = 0; #1;
    check("p_drained", 32'(q1_count), 32'd0);
    check("p_err",     32'(q1_err), 32'd0);

    // Bypass mode: pass-through when empty, storage path otherwise
    q2_enq_en = 1; q2_deq_en = 1; enq_msg = 8'h55; #1;
    check("b_deq_rdy",  32'(q2_deq_rdy), 32'd1);
    check("b_pass_msg", 32'(q2_deq_msg), 32'h55);
    step();
    q2_enq_en = 0; q2_deq_en = 0; #1;
    check("b_pass_count", 32'(q2_count), 32'd0);
    check("b_no_dup",     32'(q2_deq_rdy), 32'd0);
    q2_enq_en = 1; enq_msg = 8'h66; step();
    check("b_write_count", 32'(q2_count), 32'd1);
    enq_msg = 8'h77; q2_deq_en = 1; #1;
    check("b_head_66", 32'(q2_deq_msg), 32'h66);
    step();
    q2_enq_en = 0; #1;
    check("b_count_1", 32'(q2_count), 32'd1);
    check("b_head_77", 32'(q2_deq_msg), 32'h77);
    step();
    q2_deq_en = 0; #1;
    check("b_drained", 32'(q2_count), 32'd0);
    check("b_err",     32'(q2_err), 32'd0);

    // Depth-3 stream with random legal handshakes
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      q3_enq_en = (sent < 10) && q3_enq_rdy && ($urandom_range(0, 1) == 1);
      q3_deq_en = q3_deq_rdy && ($urandom_range(0, 1) == 1);
      enq_msg = 8'(sent);
      #1;
      if (q3_deq_en) begin
        check("n3_order", 32'(q3_deq_msg), 32'(got));
        got++;
      end
      if (q3_enq_en) sent++;
      step();
      check("n3_count_max", 32'(32'(q3_count) <= 32'd3), 32'd1);
      cyc++;
    end
    q3_enq_en = 0; q3_deq_en = 0; #1;
    check("n3_all_out", 32'(got), 32'd10);
    check("n3_empty",   32'(q3_count), 32'd0);
    check("n3_err",     32'(q3_err), 32'd0);

    // Overflow error, clear, and asynchronous reset
    q0_enq_en = 1; enq_msg = 8'h31; step();
    enq_msg = 8'h32; step();
    enq_msg = 8'h33; #1;
    check("e_full_rdy", 32'(q0_enq_rdy), 32'd0);
    step();
    q0_enq_en = 0; #1;
    check("e_count", 32'(q0_count), 32'd2);
    check("e_err",   32'(q0_err), 32'd1);
    check("e_head",  32'(q0_deq_msg), 32'h31);
    clear = 1; step();
    clear = 0; #1;
    check("c_count",   32'(q0_count), 32'd0);
    check("c_err",     32'(q0_err), 32'd1);
    check("c_deq_rdy", 32'(q0_deq_rdy), 32'd0);
    q0_enq_en = 1; enq_msg = 8'h34; step();
    q0_enq_en = 0; #1;
    check("r_pre_count", 32'(q0_count), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("r_async_count", 32'(q0_count), 32'd0);
    check("r_async_err",   32'(q0_err), 32'd0);
    #2 reset = 1'b0;
    step();

    // Clear wins over same-cycle enqueue and dequeue
    q4_enq_en = 1; enq_msg = 8'h41; step();
    enq_msg = 8'h42; step();
    clear = 1; enq_msg = 8'h43; q4_deq_en = 1; step();
    clear = 0; q4_enq_en = 0; q4_deq_en = 0; #1;
    check("cf_count",   32'(q4_count), 32'd0);
    check("cf_deq_rdy", 32'(q4_deq_rdy), 32'd0);
    q4_enq_en = 1; enq_msg = 8'h44; step();
    q4_enq_en = 0; #1;
    check("cf_count_1", 32'(q4_count), 32'd1);
    check("cf_head",    32'(q4_deq_msg), 32'h44);
    check("cf_err",     32'(q4_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
